rot_arbiter: RTL
================

Name: rot_arbiter

Overview:
- Time-shares one rotate-right datapath (DATA_WIDTH-bit rotate by variable amount) between two requesters.
- Arbitrates round-robin and converts rotate-left requests to the equivalent rotate-right.
- Captures the result in a one-entry output buffer with valid/ready handshakes on both sides.
- Sits between the decode/execute issue slots and the shared rotate unit in the CPU datapath.

Parameters:
DATA_WIDTH, 20, operand/result width
AMT_WIDTH, 5, width of rotate-amount fields

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset
req0_valid  input  1  requester 0 has an operation
req0_ready  output  1  requester 0 operation accepted this cycle
req0_data  input  DATA_WIDTH  requester 0 operand
req0_amount  input  AMT_WIDTH  requester 0 rotate amount
req0_left  input  1  1 = rotate left, 0 = rotate right
req1_valid  input  1  requester 1 has an operation
req1_ready  output  1  requester 1 operation accepted this cycle
req1_data  input  DATA_WIDTH  requester 1 operand
req1_amount  input  AMT_WIDTH  requester 1 rotate amount
req1_left  input  1  1 = rotate left, 0 = rotate right
resp_valid  output  1  result buffer holds a result
resp_ready  input  1  consumer takes result this cycle
resp_data  output  DATA_WIDTH  rotated result
resp_id  output  1  index of the requester that issued the result

Behaviour:
- Reset (rst_n low at clk edge): resp_valid=0, resp_data=0, resp_id=0, priority pointer=0. req*_ready is combinational and is 0 while rst_n is low.
- Effective amount: eff = amount mod DATA_WIDTH, taken over the full AMT_WIDTH range. Example for DATA_WIDTH=20: 23->3, 20->0, 31->11.
- Left-to-right conversion: a left rotate is issued as right rotate by (DATA_WIDTH - eff) mod DATA_WIDTH. Left by 0 is right by 0.
- Slot free: slot_free = !resp_valid || resp_ready.
- Grant is combinational:
  - If slot_free and exactly one requester is valid, that requester is granted.
  - If slot_free and both are valid, the requester equal to the priority pointer is granted.
  - reqN_ready = grantN. At most one ready is high per cycle.
- Accept: on the cycle a grant occurs, next edge loads resp_data with the rotate result, resp_id with the granted index, and sets resp_valid=1. Latency from accept to resp_valid is 1 cycle. Throughput is 1 op/cycle when resp_ready is held high.
- Priority pointer: after any grant, pointer = ~granted index. Pointer is unchanged when there is no grant.
- Drain: resp_ready=1 with resp_valid=1 and no new grant -> resp_valid=0 next edge. resp_data and resp_id hold their last values.
- Simultaneous drain and accept: the new result overwrites the buffer and resp_valid stays 1. No bubble, no loss.
- Back-pressure: while resp_valid=1 and resp_ready=0, both readys are 0, and resp_data/resp_id are stable until taken.
- Requesters may drop or change valid, data or amount while not granted. There is no requirement on input stability before grant.
- Reset mid-operation: the buffered result is discarded and the pointer returns to 0. No response is produced for it.
- Internal state: output buffer plus pointer. Two implicit states, EMPTY (resp_valid=0) and FULL (resp_valid=1):
  - EMPTY -> FULL on grant.
  - FULL -> EMPTY on resp_ready with no grant.
  - FULL -> FULL on hold, or on drain plus grant.

Test Plan:
- Reset then single op: req0 data=20'hEC880, amount=4, left=0, resp_ready=1 -> req0_ready=1 same cycle; next cycle resp_valid=1, resp_data=20'h0EC88, resp_id=0.
- Modulo and left rotate:
  - req1 data=20'hEC880, amount=23, right -> 20'h1D910, id=1.
  - amount=20 -> 20'hEC880.
  - amount=4, left=1 -> 20'hC880E.
  - amount=1, right -> 20'h76440.
- Contention: both valid continuously, resp_ready=1, data0=20'hEC880 amt 1, data1=20'hEC880 amt 4 -> grants alternate 0,1,0,1 starting at 0. resp_id alternates and each result matches its requester.
- Back-pressure: fill buffer, hold resp_ready=0 for 3 cycles with both requesters valid -> both readys 0, resp_data/resp_id unchanged. Raise resp_ready -> drain and new accept in the same cycle, resp_valid stays 1.
- Reset mid-operation: buffer full, assert rst_n=0 for one cycle -> resp_valid=0, resp_data=0, readys=0. After release, contention grants requester 0 first.
- Random stream (seeded): random data/amount/dir/valid/resp_ready for 1000 cycles -> every accepted op is returned exactly once, in accept order, with correct rotate result and id.

Source files
------------

// File: rtl/rot_arbiter.sv
// Two-requester round-robin front end for a shared rotate-right unit.
// A left rotate is issued as the equivalent right rotate. The result
// lands in a one-entry output buffer with a valid/ready handshake.
module rot_arbiter #(
  parameter int DATA_WIDTH = 20,
  parameter int AMT_WIDTH  = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [DATA_WIDTH-1:0] req0_data,
  input  logic [AMT_WIDTH-1:0]  req0_amount,
  input  logic                  req0_left,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [DATA_WIDTH-1:0] req1_data,
  input  logic [AMT_WIDTH-1:0]  req1_amount,
  input  logic                  req1_left,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic                  resp_id
);

  // Wide enough to hold any right-rotate distance 0..DATA_WIDTH-1.
  localparam int SH_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    id_q, id_d;
  logic                    ptr_q, ptr_d;

  logic                    slot_free;
  logic                    grant0, grant1, grant_any, grant_id;
  logic [DATA_WIDTH-1:0]   sel_data;
  logic [AMT_WIDTH-1:0]    sel_amount;
  logic                    sel_left;
  logic [SH_W-1:0]         shift_amt;
  logic [2*DATA_WIDTH-1:0] doubled;
  logic [DATA_WIDTH-1:0]   rot_result;

  // Reduce the raw amount modulo DATA_WIDTH; a left rotate by eff becomes a
  // right rotate by (DATA_WIDTH - eff), with left-by-0 staying at 0.
  function automatic logic [SH_W-1:0] right_amount(input logic [AMT_WIDTH-1:0] amt,
                                                   input logic                 left);
    int eff;
    eff = int'(amt) % DATA_WIDTH;
    if (left && (eff != 0)) begin
      eff = DATA_WIDTH - eff;
    end
    return SH_W'(eff);
  endfunction

  // Round-robin grant; the pointer only matters when both requesters compete.
  always_comb begin
    slot_free = (state_q == EMPTY) || resp_ready;
    grant0    = rst_n && slot_free && req0_valid && (!req1_valid || !ptr_q);
    grant1    = rst_n && slot_free && req1_valid && (!req0_valid ||  ptr_q);
    grant_any = grant0 || grant1;
    grant_id  = grant1;
  end

  // Operand select and rotate-right through a doubled operand.
  always_comb begin
    sel_data   = grant_id ? req1_data   : req0_data;
    sel_amount = grant_id ? req1_amount : req0_amount;
    sel_left   = grant_id ? req1_left   : req0_left;
    shift_amt  = right_amount(sel_amount, sel_left);
    doubled    = {sel_data, sel_data} >> shift_amt;
    rot_result = doubled[DATA_WIDTH-1:0];
  end

  // Next-state for the buffer occupancy, payload and priority pointer.
  always_comb begin
    // NOTE: every signal gets a hold value first so no path leaves it unassigned (no latch).
    state_d = state_q;
    data_d  = data_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      EMPTY: if (grant_any) state_d = FULL;
      FULL: begin
        if (grant_any)       state_d = FULL;
        else if (resp_ready) state_d = EMPTY;
      end
    endcase
    // Payload and id hold after a drain; only a new grant overwrites them.
    if (grant_any) begin
      data_d = rot_result;
      id_d   = grant_id;
      ptr_d  = ~grant_id;
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rst_n) begin
      // NOTE: the result buffer is a single register, so it is cleared on reset like any other flop.
      state_q <= EMPTY;
      data_q  <= '0;
      id_q    <= 1'b0;
      ptr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign resp_valid = (state_q == FULL);
  assign resp_data  = data_q;
  assign resp_id    = id_q;

endmodule
